// File: rtl/red_pitaya_dac_conditioner.sv
// red_pitaya_dac_conditioner
// Multi-channel DAC sample conditioner ahead of the ODDR lane-interleave stage.
// Per channel: capture + saturate -> slew limit -> soft-start/stop gain -> DAC code.
// Optional feature macro: RED_PITAYA_DAC_SLEW_EN
//   defined   : stage 2 limits the per-cycle step to slew_max_i (0 = unlimited)
//   undefined : stage 2 is a plain register and slew_max_i is ignored
// Four register stages (held, lim, scaled, code): a sample captured at edge n
// is on dac_code_o after edge n+3, so the ODDR stage takes it at edge n+4.
module red_pitaya_dac_conditioner #(
    parameter int NUM_CH         = 2,
    parameter int IN_WIDTH       = 16,
    parameter int DAC_DATA_WIDTH = 14,
    parameter int RAMP_BITS      = 10,
    parameter int SLEW_WIDTH     = 14
) (
    input  logic                               aclk,
    input  logic                               arst,
    input  logic                               enable_i,
    input  logic [NUM_CH*IN_WIDTH-1:0]         dat_i,
    input  logic                               dat_valid_i,
    input  logic [SLEW_WIDTH-1:0]              slew_max_i,
    input  logic                               sat_clr_i,
    output logic [NUM_CH*DAC_DATA_WIDTH-1:0]   dac_code_o,
    output logic                               dac_active_o,
    output logic [NUM_CH-1:0]                  sat_o
);

    localparam int D = DAC_DATA_WIDTH;
    localparam int R = RAMP_BITS;

    localparam logic [R:0]   G_FULL    = {1'b1, {R{1'b0}}};
    localparam logic [D-1:0] CODE_MID  = {1'b0, {(D-1){1'b1}}};
    localparam logic [D-1:0] CLIP_POS  = {1'b0, {(D-1){1'b1}}};
    localparam logic [D-1:0] CLIP_NEG  = {1'b1, {(D-1){1'b0}}};
    localparam logic signed [IN_WIDTH-1:0] IN_MAX = {{(IN_WIDTH-D+1){1'b0}}, {(D-1){1'b1}}};
    localparam logic signed [IN_WIDTH-1:0] IN_MIN = {{(IN_WIDTH-D+1){1'b1}}, {(D-1){1'b0}}};

    // state      | meaning
    // S_OFF      | gain held at 0, output at midscale
    // S_RAMP_UP  | gain climbs by 1 per cycle toward full scale
    // S_RUN      | full gain, dac_active_o high
    // S_RAMP_DOWN| gain falls by 1 per cycle toward 0
    typedef enum logic [1:0] {
        S_OFF       = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_RUN       = 2'd2,
        S_RAMP_DOWN = 2'd3
    } ramp_state_t;

    ramp_state_t state_q, state_d;
    logic [R:0]  g_q, g_d;

`ifndef RED_PITAYA_DAC_SLEW_EN
    logic unused_slew;
    assign unused_slew = ^slew_max_i;
`endif

    // Ramp state and shared gain register
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q      <= S_OFF;
            g_q          <= '0;
            dac_active_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            dac_active_o <= (state_d == S_RUN);
        end
    end

    // Ramp next-state: direction changes keep the current gain and ramp from there
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        unique case (state_q)
            S_OFF: begin
                g_d = '0;
                if (enable_i) state_d = S_RAMP_UP;
            end
            S_RAMP_UP: begin
                if (!enable_i) begin
                    state_d = S_RAMP_DOWN;
                end else if (g_q >= G_FULL - 1'b1) begin
                    g_d     = G_FULL;
                    state_d = S_RUN;
                end else begin
                    g_d = g_q + 1'b1;
                end
            end
            S_RUN: begin
                g_d = G_FULL;
                if (!enable_i) state_d = S_RAMP_DOWN;
            end
            S_RAMP_DOWN: begin
                if (enable_i) begin
                    state_d = S_RAMP_UP;
                end else if (g_q <= {{R{1'b0}}, 1'b1}) begin
                    g_d     = '0;
                    state_d = S_OFF;
                end else begin
                    g_d = g_q - 1'b1;
                end
            end
            default: begin
                state_d = S_OFF;
                g_d     = '0;
            end
        endcase
    end

    // Gain as a non-negative signed operand wide enough for the full product
    logic signed [D+R+1:0] g_w;
    assign g_w = {{(D+1){1'b0}}, g_q};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic signed [IN_WIDTH-1:0] in_s;
        logic                       over, under;
        logic [D-1:0]               clip_v;
        logic signed [D-1:0]        held_q, lim_q, lim_d, scaled_q;
        logic [D-1:0]               code_q;
        logic                       sat_q;
        logic signed [D+R+1:0]      lim_w;

        assign in_s   = dat_i[k*IN_WIDTH +: IN_WIDTH];
        assign over   = (in_s > IN_MAX);
        assign under  = (in_s < IN_MIN);
        assign clip_v = over ? CLIP_POS : (under ? CLIP_NEG : in_s[D-1:0]);

        // Stage 1: zero-order hold of the clipped sample; sticky saturation flag
        always_ff @(posedge aclk or posedge arst) begin
            if (arst) begin
                held_q <= '0;
                sat_q  <= 1'b0;
            end else begin
                if (dat_valid_i) held_q <= clip_v;
                if (dat_valid_i && (over || under)) sat_q <= 1'b1;
                else if (sat_clr_i)                 sat_q <= 1'b0;
            end
        end

`ifdef RED_PITAYA_DAC_SLEW_EN
        localparam int W = ((SLEW_WIDTH > D + 1) ? SLEW_WIDTH : D + 1) + 1;
        logic signed [W-1:0] held_x, lim_x, step_x, diff_x, mag_x;

        // Slew limit: move lim toward held by at most slew_max_i per cycle
        always_comb begin
            held_x = {{(W-D){held_q[D-1]}}, held_q};
            lim_x  = {{(W-D){lim_q[D-1]}}, lim_q};
            step_x = {{(W-SLEW_WIDTH){1'b0}}, slew_max_i};
            diff_x = held_x - lim_x;
            mag_x  = diff_x[W-1] ? -diff_x : diff_x;
            if ((slew_max_i == '0) || (mag_x <= step_x)) lim_d = held_q;
            else if (diff_x[W-1])                         lim_d = D'(lim_x - step_x);
            else                                          lim_d = D'(lim_x + step_x);
        end
`else
        assign lim_d = held_q;
`endif

        // Stage 2: slew-limited (or plain) copy of the held sample
        always_ff @(posedge aclk or posedge arst) begin
            if (arst) lim_q <= '0;
            else      lim_q <= lim_d;
        end

        assign lim_w = {{(R+2){lim_q[D-1]}}, lim_q};

        // Stage 3: gain scaling, arithmetic shift floors toward -inf
        always_ff @(posedge aclk or posedge arst) begin
            if (arst) scaled_q <= '0;
            else      scaled_q <= D'((lim_w * g_w) >>> R);
        end

        // Stage 4: DAC format, inverted offset binary with midscale at reset
        always_ff @(posedge aclk or posedge arst) begin
            if (arst) code_q <= CODE_MID;
            else      code_q <= {scaled_q[D-1], ~scaled_q[D-2:0]};
        end

        assign dac_code_o[k*D +: D] = code_q;
        assign sat_o[k]             = sat_q;
    end

endmodule

// File: tb/tb_red_pitaya_dac_conditioner.sv
// Self-checking bench for red_pitaya_dac_conditioner (default parameters).
// Reference model works on plain integers: clip, slew, floor-scaled gain and
// code = MID - value, advanced once per clock.
module tb_red_pitaya_dac_conditioner;

    localparam int NUM_CH = 2;
    localparam int IN_W   = 16;
    localparam int D      = 14;
    localparam int RB     = 10;
    localparam int SW     = 14;
    localparam int FULL   = 1 << RB;
    localparam int MAXV   = (1 << (D - 1)) - 1;
    localparam int MINV   = -(1 << (D - 1));
    localparam int MID    = MAXV;
    localparam int M_OFF = 0, M_UP = 1, M_RUN = 2, M_DOWN = 3;

    logic                     aclk = 1'b0;
    logic                     arst = 1'b1;
    logic                     enable_i = 1'b0;
    logic [NUM_CH*IN_W-1:0]   dat_i = '0;
    logic                     dat_valid_i = 1'b0;
    logic [SW-1:0]            slew_max_i = '0;
    logic                     sat_clr_i = 1'b0;
    logic [NUM_CH*D-1:0]      dac_code_o;
    logic                     dac_active_o;
    logic [NUM_CH-1:0]        sat_o;

    red_pitaya_dac_conditioner #(
        .NUM_CH(NUM_CH), .IN_WIDTH(IN_W), .DAC_DATA_WIDTH(D),
        .RAMP_BITS(RB), .SLEW_WIDTH(SW)
    ) dut (
        .aclk(aclk), .arst(arst), .enable_i(enable_i), .dat_i(dat_i),
        .dat_valid_i(dat_valid_i), .slew_max_i(slew_max_i), .sat_clr_i(sat_clr_i),
        .dac_code_o(dac_code_o), .dac_active_o(dac_active_o), .sat_o(sat_o)
    );

    always #5 aclk = ~aclk;

    int in_val[NUM_CH];
    int m_held[NUM_CH], m_lim[NUM_CH], m_scaled[NUM_CH], m_code[NUM_CH];
    bit m_sat[NUM_CH];
    int m_g, m_mode;
    bit m_active;
    int n_pass = 0, n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int clip(input int v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic int fdiv(input int p);
        if (p >= 0) return p / FULL;
        return -((-p + FULL - 1) / FULL);
    endfunction

    function automatic int slew_model(input int held, input int lim, input int smax);
`ifdef RED_PITAYA_DAC_SLEW_EN
        int d = held - lim;
        int a = (d < 0) ? -d : d;
        if (smax == 0 || a <= smax) return held;
        return (d > 0) ? lim + smax : lim - smax;
`else
        return held;
`endif
    endfunction

    function automatic int code_of(input int ch);
        return int'(dac_code_o[ch*D +: D]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_held[k] = 0; m_lim[k] = 0; m_scaled[k] = 0; m_code[k] = MID; m_sat[k] = 0;
        end
        m_g = 0; m_mode = M_OFF; m_active = 0;
    endtask

    task automatic pack();
        for (int k = 0; k < NUM_CH; k++) dat_i[k*IN_W +: IN_W] = IN_W'(in_val[k]);
    endtask

    // one clock: compute model next state from current inputs, take the edge, commit
    task automatic step();
        int nh[NUM_CH], nl[NUM_CH], ns[NUM_CH], nc[NUM_CH];
        bit nsat[NUM_CH];
        int ng, nm;
        bit clipped;
        pack();
        for (int k = 0; k < NUM_CH; k++) begin
            nc[k]   = MID - m_scaled[k];
            ns[k]   = fdiv(m_lim[k] * m_g);
            nl[k]   = slew_model(m_held[k], m_lim[k], int'(slew_max_i));
            clipped = (in_val[k] > MAXV) || (in_val[k] < MINV);
            nh[k]   = dat_valid_i ? clip(in_val[k]) : m_held[k];
            nsat[k] = (dat_valid_i && clipped) ? 1'b1 : (sat_clr_i ? 1'b0 : m_sat[k]);
        end
        ng = m_g; nm = m_mode;
        case (m_mode)
            M_OFF:  begin ng = 0; nm = enable_i ? M_UP : M_OFF; end
            M_UP:   if (!enable_i) nm = M_DOWN;
                    else begin ng = (m_g + 1 > FULL) ? FULL : m_g + 1; nm = (ng == FULL) ? M_RUN : M_UP; end
            M_RUN:  begin ng = FULL; nm = enable_i ? M_RUN : M_DOWN; end
            default: if (enable_i) nm = M_UP;
                    else begin ng = (m_g - 1 < 0) ? 0 : m_g - 1; nm = (ng == 0) ? M_OFF : M_DOWN; end
        endcase
        @(posedge aclk);
        for (int k = 0; k < NUM_CH; k++) begin
            m_held[k] = nh[k]; m_lim[k] = nl[k]; m_scaled[k] = ns[k]; m_code[k] = nc[k]; m_sat[k] = nsat[k];
        end
        m_g = ng; m_mode = nm; m_active = (nm == M_RUN);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [NUM_CH-1:0] es;
        for (int k = 0; k < NUM_CH; k++) begin
            check($sformatf("%s_code%0d", tag, k), 32'(code_of(k)), 32'(m_code[k]));
            es[k] = m_sat[k];
        end
        check({tag, "_active"}, 32'(dac_active_o), 32'(m_active));
        check({tag, "_sat"}, 32'(sat_o), 32'(es));
    endtask

    task automatic check_reset_consts(input string tag);
        for (int k = 0; k < NUM_CH; k++) check($sformatf("%s_code%0d", tag, k), 32'(code_of(k)), 32'h1FFF);
        check({tag, "_active"}, 32'(dac_active_o), 32'd0);
        check({tag, "_sat"}, 32'(sat_o), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev, rise, ret;
        model_reset();
        for (int k = 0; k < NUM_CH; k++) in_val[k] = 0;
        pack();
        repeat (2) @(posedge aclk);
        #1;
        check_reset_consts("por");
        @(negedge aclk);
        arst = 1'b0;
        #1;
        step();
        check_all("post_rst");

        // soft start with constant 4096 on every channel
        for (int k = 0; k < NUM_CH; k++) in_val[k] = 4096;
        dat_valid_i = 1'b1;
        repeat (5) step();
        check_all("pre_start");
        enable_i = 1'b1;
        prev = code_of(0);
        rise = -1;
        for (int c = 1; c <= 1100; c++) begin
            step();
            check_all("start");
            check("start_mono", 32'(code_of(0) <= prev), 32'd1);
            prev = code_of(0);
            if (dac_active_o && rise < 0) rise = c;
        end
        check("active_delay", 32'(rise - 1), 32'd1024);
        for (int k = 0; k < NUM_CH; k++) check($sformatf("start_final%0d", k), 32'(code_of(k)), 32'h0FFF);

        // random traffic at full gain
        for (int i = 0; i < 80; i++) begin
            for (int k = 0; k < NUM_CH; k++)
                in_val[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                                        : int'($urandom_range(0, 16383)) - 8192;
            dat_valid_i = ($urandom_range(0, 3) != 0);
            slew_max_i  = SW'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 600));
            sat_clr_i   = ($urandom_range(0, 7) == 0);
            step();
            check_all("rand");
        end

        // saturation and sticky flags
        slew_max_i = '0; dat_valid_i = 1'b0; sat_clr_i = 1'b1;
        step();
        sat_clr_i = 1'b0;
        check("sat_cleared", 32'(sat_o), 32'd0);
        in_val[0] = 32'h7FFF; in_val[1] = -32768; dat_valid_i = 1'b1;
        repeat (4) step();
        check("sat_code0", 32'(code_of(0)), 32'h0000);
        check("sat_code1", 32'(code_of(1)), 32'h3FFF);
        check("sat_flags", 32'(sat_o), 32'h3);
        dat_valid_i = 1'b0; sat_clr_i = 1'b1;
        step();
        check("sat_clr", 32'(sat_o), 32'h0);
        dat_valid_i = 1'b1;
        step();
        check("sat_clr_vs_set", 32'(sat_o), 32'h3);
        in_val[0] = 9000; in_val[1] = 0;
        step();
        check("sat_partial", 32'(sat_o), 32'h1);
        sat_clr_i = 1'b0;
        check_all("sat_model");

        // slew: step 0 -> 1000 with limit 100
        in_val[0] = 0; in_val[1] = 0; slew_max_i = '0;
        repeat (6) step();
        in_val[0] = 1000; in_val[1] = 1000; slew_max_i = SW'(100);
        for (int s = 1; s <= 14; s++) begin
            step();
`ifdef RED_PITAYA_DAC_SLEW_EN
            if (s >= 3) check($sformatf("slew_s%0d", s), 32'(code_of(0)),
                              32'(MID - ((100 * (s - 3) > 1000) ? 1000 : 100 * (s - 3))));
`else
            check($sformatf("noslew_s%0d", s), 32'(code_of(0)), 32'(s >= 4 ? MID - 1000 : MID));
`endif
            check_all("slew");
        end
        // slew_max 0: full step lands on the fourth edge
        slew_max_i = '0; in_val[0] = -1000; in_val[1] = -1000;
        repeat (3) step();
        check("lat_before", 32'(code_of(0)), 32'(MID - 1000));
        step();
        check("lat_after", 32'(code_of(0)), 32'(MID + 1000));

        // hold: valid low while inputs wander
        in_val[0] = 1234; in_val[1] = -2000;
        repeat (5) step();
        dat_valid_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < NUM_CH; k++) in_val[k] = int'($urandom_range(0, 65535)) - 32768;
            step();
            check("hold0", 32'(code_of(0)), 32'(MID - 1234));
            check("hold1", 32'(code_of(1)), 32'(MID + 2000));
        end

        // ramp reversal
        for (int k = 0; k < NUM_CH; k++) in_val[k] = 4096;
        dat_valid_i = 1'b1; enable_i = 1'b0;
        for (int i = 0; i < 1200 && m_mode != M_OFF; i++) begin step(); check_all("down"); end
        enable_i = 1'b1;
        for (int i = 0; i < 1200 && !(m_mode == M_UP && m_g == 300); i++) begin step(); check_all("up300"); end
        enable_i = 1'b0;
        ret = -1;
        for (int c = 1; c <= 400; c++) begin
            step();
            check_all("drop");
            if (code_of(0) == MID && ret < 0) ret = c;
        end
        check("off_after_300", 32'(ret - 3), 32'd300);
        enable_i = 1'b1;
        for (int i = 0; i < 1200 && !(m_mode == M_UP && m_g == 400); i++) step();
        enable_i = 1'b0;
        for (int i = 0; i < 1200 && !(m_mode == M_DOWN && m_g == 150); i++) begin step(); check_all("dn150"); end
        enable_i = 1'b1;
        for (int s = 1; s <= 20; s++) begin step(); check_all("rev"); end
        check("rev_from150", 32'(code_of(0)), 32'(MID - 4 * (150 + 17)));

        // asynchronous reset in the middle of streaming
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < NUM_CH; k++) in_val[k] = int'($urandom_range(0, 65535)) - 32768;
            step();
        end
        @(negedge aclk);
        #2 arst = 1'b1;
        #1;
        check_reset_consts("mid_rst");
        model_reset();
        enable_i = 1'b0;
        @(posedge aclk);
        #1;
        check_reset_consts("mid_rst_hold");
        @(negedge aclk);
        arst = 1'b0;
        step();
        check_all("after_rst");
        repeat (4) step();
        check_all("after_rst2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
